// File: rtl/adc_pulse_capture.sv
// adc_pulse_capture: threshold-triggered pre/post capture of one ADC channel into
// a circular buffer, then readout of the frozen record over valid/ready.
// Ports:
//   sys_clk, reset_n            clock, async active-low reset
//   a2da_data, a2db_data        channel A/B samples (one per clock)
//   ch_sel, fmt_twos, threshold capture configuration, latched on arm
//   arm, abort                  start request / synchronous cancel
//   rd_ready, rd_valid, rd_data, rd_last   record stream
//   busy, triggered, record_count          status
module adc_pulse_capture #(
    parameter int unsigned DATA_W = 14,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned PRE    = 16,
    parameter int unsigned POST   = 112
) (
    input  logic              sys_clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] a2da_data,
    input  logic [DATA_W-1:0] a2db_data,
    input  logic              ch_sel,
    input  logic              fmt_twos,
    input  logic [DATA_W-1:0] threshold,
    input  logic              arm,
    input  logic              abort,
    input  logic              rd_ready,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    output logic              busy,
    output logic              triggered,
    output logic [15:0]       record_count
);

    localparam int unsigned DEPTH   = 1 << ADDR_W;
    localparam int unsigned CNT_W   = ADDR_W + 1;
    localparam int unsigned REC_LEN = PRE + POST;

    if (PRE < 1 || POST < 1 || REC_LEN > DEPTH) begin : g_bad_params
        $error("adc_pulse_capture: need PRE>=1, POST>=1, PRE+POST<=2**ADDR_W");
    end

    typedef enum logic [2:0] {IDLE, PREFILL, WAIT_TRIG, CAPTURE, READOUT} state_t;

    state_t              state, state_nxt;
    logic                sel_q, twos_q;
    logic [DATA_W-1:0]   thr_q, prev;
    logic [ADDR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]    fill_cnt, post_cnt, issue_cnt;
    logic                s1_v, s1_last;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [DATA_W-1:0]   ram_q;

    logic [DATA_W-1:0]   cur_c, bias_c;
    logic                cross_c, out_free_c, issue_c, xfer_last_c;
    logic                wr_en_c, load_cfg_c, trig_c;

    // Selected sample; flipping the MSB of two's-complement values maps them onto
    // offset-binary order so a single unsigned compare serves both formats.
    assign cur_c       = sel_q ? a2db_data : a2da_data;
    assign bias_c      = {twos_q, {(DATA_W-1){1'b0}}};
    assign cross_c     = ((prev ^ bias_c) < (thr_q ^ bias_c)) &&
                         ((cur_c ^ bias_c) >= (thr_q ^ bias_c));

    // Readout pipeline: RAM output stage (s1) feeding the output register.
    assign out_free_c  = !rd_valid || rd_ready;
    assign issue_c     = (state == READOUT) && (out_free_c || !s1_v) &&
                         (issue_cnt < CNT_W'(REC_LEN));
    assign xfer_last_c = rd_valid && rd_ready && rd_last;

    // State register
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next state and per-cycle control strobes
    always_comb begin
        state_nxt  = state;
        wr_en_c    = 1'b0;
        load_cfg_c = 1'b0;
        trig_c     = 1'b0;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: if (arm) begin
                    load_cfg_c = 1'b1;
                    state_nxt  = PREFILL;
                end
                PREFILL: begin
                    wr_en_c = 1'b1;
                    if (fill_cnt == CNT_W'(PRE - 1)) state_nxt = WAIT_TRIG;
                end
                WAIT_TRIG: begin
                    wr_en_c = 1'b1;
                    if (cross_c) begin
                        trig_c    = 1'b1;
                        state_nxt = (POST == 1) ? READOUT : CAPTURE;
                    end
                end
                CAPTURE: begin
                    wr_en_c = 1'b1;
                    if (post_cnt == CNT_W'(1)) state_nxt = READOUT;
                end
                READOUT: if (xfer_last_c) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Sample buffer with registered read port
    always_ff @(posedge sys_clk) begin
        if (wr_en_c) mem[wr_ptr] <= cur_c;
        if (issue_c) ram_q <= mem[rd_ptr];
    end

    // Datapath, readout pipeline and status registers
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            sel_q        <= 1'b0;
            twos_q       <= 1'b0;
            thr_q        <= '0;
            prev         <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fill_cnt     <= '0;
            post_cnt     <= '0;
            issue_cnt    <= '0;
            s1_v         <= 1'b0;
            s1_last      <= 1'b0;
            rd_valid     <= 1'b0;
            rd_data      <= '0;
            rd_last      <= 1'b0;
            busy         <= 1'b0;
            triggered    <= 1'b0;
            record_count <= '0;
        end else begin
            busy <= (state_nxt != IDLE);
            if (load_cfg_c) begin
                sel_q     <= ch_sel;
                twos_q    <= fmt_twos;
                thr_q     <= threshold;
                wr_ptr    <= '0;
                fill_cnt  <= '0;
                issue_cnt <= '0;
            end
            if (wr_en_c) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
                prev   <= cur_c;
            end
            if (wr_en_c && state == PREFILL) fill_cnt <= fill_cnt + CNT_W'(1);
            // Record starts PRE entries before the trigger write address
            if (trig_c) begin
                rd_ptr   <= wr_ptr - ADDR_W'(PRE);
                post_cnt <= CNT_W'(POST - 1);
            end
            if (wr_en_c && state == CAPTURE) post_cnt <= post_cnt - CNT_W'(1);

            if (abort) begin
                s1_v      <= 1'b0;
                rd_valid  <= 1'b0;
                rd_last   <= 1'b0;
                triggered <= 1'b0;
            end else begin
                if (trig_c)           triggered <= 1'b1;
                else if (xfer_last_c) triggered <= 1'b0;

                if (issue_c) begin
                    rd_ptr    <= rd_ptr + ADDR_W'(1);
                    issue_cnt <= issue_cnt + CNT_W'(1);
                    s1_v      <= 1'b1;
                    s1_last   <= (issue_cnt == CNT_W'(REC_LEN - 1));
                end else if (out_free_c) begin
                    s1_v <= 1'b0;
                end

                // Output register only advances when empty or being consumed
                if (out_free_c) begin
                    rd_valid <= s1_v;
                    rd_last  <= s1_v && s1_last;
                    if (s1_v) rd_data <= ram_q;
                end

                if (xfer_last_c) record_count <= record_count + 16'd1;
            end
        end
    end

endmodule
